// File: rtl/excess5_decoder.sv
// Serial excess-5 price decoder: captures a 6-bit MSB-first frame and maps legal codes to euros.
// Optional even-parity trailer bit is enabled by defining EXCESS5_DECODER_PARITY_EN.
module excess5_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       startIn,
  input  logic       bitValid,
  input  logic       serialIn,
  output logic [4:0] valueToPay,
  output logic       valid,
  output logic       error,
  output logic       busy
);

`ifdef EXCESS5_DECODER_PARITY_EN
  localparam logic [2:0] LastIdx = 3'd6;
`else
  localparam logic [2:0] LastIdx = 3'd5;
`endif

  typedef enum logic [1:0] {StIdle, StShift, StCheck} state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [5:0] shift_q, shift_d;
  logic [4:0] value_q, value_d;
  logic       valid_q, valid_d;
  logic       error_q, error_d;

  // Frame content presented to the decoder on the cycle the last bit is accepted.
  logic [5:0] final_code;
  logic       code_legal;
  logic [5:0] code_minus5;
  logic       parity_bad;

`ifdef EXCESS5_DECODER_PARITY_EN
  logic par_q, par_d;
`endif

  always_comb begin
    unique case (final_code)
      6'd0, 6'd7, 6'd9, 6'd11, 6'd13, 6'd15, 6'd17,
      6'd19, 6'd21, 6'd25, 6'd29, 6'd33: code_legal = 1'b1;
      default:                           code_legal = 1'b0;
    endcase
  end

  assign code_minus5 = final_code - 6'd5;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    value_d    = value_q;
    valid_d    = 1'b0;
    error_d    = 1'b0;
    final_code = shift_q;
    parity_bad = 1'b0;
`ifdef EXCESS5_DECODER_PARITY_EN
    par_d      = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (startIn) begin
          state_d = StShift;
          cnt_d   = 3'd0;
          shift_d = 6'd0;
`ifdef EXCESS5_DECODER_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      StShift: begin
        if (startIn) begin
          // Restart capture silently; the partial frame is dropped.
          cnt_d   = 3'd0;
          shift_d = 6'd0;
`ifdef EXCESS5_DECODER_PARITY_EN
          par_d   = 1'b0;
`endif
        end else if (bitValid) begin
`ifdef EXCESS5_DECODER_PARITY_EN
          if (cnt_q == LastIdx) begin
            final_code = shift_q;
            parity_bad = par_q ^ serialIn;
          end else begin
            shift_d = {shift_q[4:0], serialIn};
            par_d   = par_q ^ serialIn;
          end
`else
          shift_d    = {shift_q[4:0], serialIn};
          final_code = shift_d;
`endif
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == LastIdx) begin
            state_d = StCheck;
            cnt_d   = 3'd0;
            if (code_legal && !parity_bad) begin
              value_d = (final_code == 6'd0) ? 5'd0 : code_minus5[4:0];
              valid_d = 1'b1;
            end else begin
              error_d = 1'b1;
            end
          end
        end
      end
      StCheck: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      shift_q <= 6'd0;
      value_q <= 5'd0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      value_q <= value_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

`ifdef EXCESS5_DECODER_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) par_q <= 1'b0;
    else       par_q <= par_d;
  end
`endif

  assign valueToPay = value_q;
  assign valid      = valid_q;
  assign error      = error_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_excess5_decoder.sv
// Directed self-checking bench for excess5_decoder; parity cases run when
// EXCESS5_DECODER_PARITY_EN is defined.
module tb_excess5_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       startIn;
  logic       bitValid;
  logic       serialIn;
  logic [4:0] valueToPay;
  logic       valid;
  logic       error;
  logic       busy;

  int checks_total  = 0;
  int checks_passed = 0;

  excess5_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .startIn   (startIn),
    .bitValid  (bitValid),
    .serialIn  (serialIn),
    .valueToPay(valueToPay),
    .valid     (valid),
    .error     (error),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Drive one cycle of inputs and return 1 time unit after the rising edge.
  task automatic step(input logic s, input logic bv, input logic b);
    startIn  = s;
    bitValid = bv;
    serialIn = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [5:0] code, input logic par);
    for (int i = 5; i >= 0; i--) step(1'b0, 1'b1, code[i]);
`ifdef EXCESS5_DECODER_PARITY_EN
    step(1'b0, 1'b1, par);
`else
    if (par === 1'bx) $error("FAIL parity_arg: observed x expected 0/1");
`endif
  endtask

  task automatic send_frame(input logic [5:0] code, input logic par);
    step(1'b1, 1'b0, 1'b0);
    send_bits(code, par);
  endtask

  task automatic chk_result(input string tag, input logic v, input logic e,
                            input logic [4:0] val);
    chk({tag, "_valid"}, {7'd0, valid}, {7'd0, v});
    chk({tag, "_error"}, {7'd0, error}, {7'd0, e});
    chk({tag, "_value"}, {3'd0, valueToPay}, {3'd0, val});
    chk({tag, "_busy"}, {7'd0, busy}, 8'd1);
  endtask

  initial begin
    reset    = 1'b1;
    startIn  = 1'b0;
    bitValid = 1'b0;
    serialIn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_value", {3'd0, valueToPay}, 8'd0);
    chk("rst_valid", {7'd0, valid}, 8'd0);
    chk("rst_error", {7'd0, error}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    reset = 1'b0;
    step(1'b0, 1'b1, 1'b1);
    chk("idle_ignores_bits", {7'd0, busy}, 8'd0);

    // 33 -> 28
    send_frame(6'b100001, 1'b0);
    chk_result("code33", 1'b1, 1'b0, 5'd28);
    step(1'b0, 1'b0, 1'b0);
    chk("code33_pulse_end", {7'd0, valid}, 8'd0);
    chk("code33_idle_busy", {7'd0, busy}, 8'd0);
    chk("code33_hold", {3'd0, valueToPay}, 8'd28);

    // 17 -> 12, then illegal 8 keeps 12
    send_frame(6'b010001, 1'b0);
    chk_result("code17", 1'b1, 1'b0, 5'd12);
    step(1'b0, 1'b0, 1'b0);
    send_frame(6'b001000, 1'b1);
    chk_result("code8", 1'b0, 1'b1, 5'd12);
    step(1'b0, 1'b0, 1'b0);
    chk("code8_pulse_end", {7'd0, error}, 8'd0);

    // 7 with bitValid toggling; gaps carry inverted junk bits
    step(1'b1, 1'b0, 1'b0);
    for (int i = 5; i >= 0; i--) begin
      step(1'b0, 1'b1, i < 3 ? 1'b1 : 1'b0);
      if (i != 0) begin
        step(1'b0, 1'b0, i < 3 ? 1'b0 : 1'b1);
        chk("toggle_busy", {7'd0, busy}, 8'd1);
      end
    end
`ifdef EXCESS5_DECODER_PARITY_EN
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
`endif
    chk_result("toggle7", 1'b1, 1'b0, 5'd2);
    step(1'b0, 1'b0, 1'b0);

    // Abort after 3 bits, then 25 -> 20
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    send_frame(6'b011001, 1'b1);
    chk_result("abort25", 1'b1, 1'b0, 5'd20);
    step(1'b0, 1'b0, 1'b0);

    // Start and bitValid together: that bit is not taken; 9 -> 4
    step(1'b1, 1'b1, 1'b1);
    send_bits(6'b001001, 1'b0);
    chk_result("startbit9", 1'b1, 1'b0, 5'd4);
    // startIn during CHECK is ignored
    step(1'b1, 1'b0, 1'b0);
    chk("check_start_ignored", {7'd0, busy}, 8'd0);
    step(1'b0, 1'b1, 1'b0);
    chk("check_start_still_idle", {7'd0, busy}, 8'd0);

    // Illegal codes 5 and 63
    send_frame(6'b000101, 1'b0);
    chk_result("code5", 1'b0, 1'b1, 5'd4);
    step(1'b0, 1'b0, 1'b0);
    send_frame(6'b111111, 1'b0);
    chk_result("code63", 1'b0, 1'b1, 5'd4);
    step(1'b0, 1'b0, 1'b0);

    // Reset mid-SHIFT after 4 bits
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_value", {3'd0, valueToPay}, 8'd0);
    chk("midrst_busy", {7'd0, busy}, 8'd0);
    chk("midrst_valid", {7'd0, valid}, 8'd0);
    chk("midrst_error", {7'd0, error}, 8'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("postrst_waits", {7'd0, busy}, 8'd0);
    chk("postrst_no_pulse", {6'd0, valid, error}, 8'd0);
    send_frame(6'b000000, 1'b0);
    chk_result("code0", 1'b1, 1'b0, 5'd0);
    step(1'b0, 1'b0, 1'b0);

`ifdef EXCESS5_DECODER_PARITY_EN
    send_frame(6'b001001, 1'b0);
    chk_result("par_ok9", 1'b1, 1'b0, 5'd4);
    step(1'b0, 1'b0, 1'b0);
    send_frame(6'b011001, 1'b0);
    chk_result("par_bad25", 1'b0, 1'b1, 5'd4);
    step(1'b0, 1'b0, 1'b0);
    send_frame(6'b001001, 1'b1);
    chk_result("par_bad9", 1'b0, 1'b1, 5'd4);
    step(1'b0, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/excess5_decoder.md
EXCESS5_DECODER -- requirements
Module: excess5_decoder

Interface
REQ-001 SHALL: clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL: startIn  input  1  frame-start strobe; starts or restarts frame capture.
REQ-004 SHALL: bitValid  input  1  qualifies serialIn; a bit is accepted only in a cycle with bitValid=1.
REQ-005 SHALL: serialIn  input  1  serial excess-5 code bit, MSB first.
REQ-006 SHALL: valueToPay  output  5  decoded price in euros; holds its value between frames.
REQ-007 SHALL: valid  output  1  one-cycle pulse: valueToPay updated with a legal decode.
REQ-008 SHALL: error  output  1  one-cycle pulse: frame rejected.
REQ-009 SHALL: busy  output  1  high in SHIFT and CHECK states.

Function
REQ-010 SHALL: FSM states IDLE, SHIFT, CHECK; IDLE->SHIFT on startIn=1; SHIFT->CHECK when the last frame bit is accepted; CHECK->IDLE unconditionally after one cycle.
REQ-011 SHALL: startIn cycle carries no data; bits are accepted from the next cycle onward, only when bitValid=1; cycles with bitValid=0 hold shift register and counter.
REQ-012 SHALL: frame length is 6 data bits (7 with parity, see Configuration); 3-bit counter clears on entry to SHIFT.
REQ-013 SHALL: shift register is 6 bits, left-shifting, serialIn entering at bit 0, so the first bit received ends in bit 5.
REQ-014 SHALL: legal codes and decodes: 0->0, 7->2, 9->4, 11->6, 13->8, 15->10, 17->12, 19->14, 21->16, 25->20, 29->24, 33->28; for nonzero legal codes, valueToPay = code - 5, truncated to 5 bits.
REQ-015 SHALL: in CHECK, a legal code loads valueToPay and pulses valid; any other code (e.g. 5, 8, 23, 34..63) pulses error and leaves valueToPay unchanged.
REQ-016 SHALL: valid/error assert in the cycle after the last frame bit is accepted; valid and error are never high together.
REQ-017 SHALL: startIn=1 in SHIFT aborts the current frame without error, clears counter and shift register, and restarts capture.
REQ-018 SHALL: startIn=1 in CHECK is ignored; startIn=1 and bitValid=1 in the same IDLE cycle start the frame and do not accept that bit.
REQ-019 SHALL: busy=0 only in IDLE.

Reset
REQ-020 SHALL: reset asynchronously forces IDLE, counter=0, shift register=0, valueToPay=0, valid=0, error=0, busy=0.
REQ-021 SHALL: reset during SHIFT or CHECK discards the frame with no valid/error pulse; after deassertion the block waits for startIn.

Configuration
REQ-022 SHALL: macro EXCESS5_DECODER_PARITY_EN defined -> frame is 6 data bits followed by one even-parity bit (XOR of all 7 = 0); a parity mismatch pulses error regardless of code legality; the parity bit is not shifted into the code register.
REQ-023 SHALL: macro undefined -> frame is 6 data bits; no parity logic is synthesized.

Verification
REQ-024 SHALL: startIn, then bits 100001 with bitValid=1 -> next cycle valid=1, valueToPay=28, error=0.
REQ-025 SHALL: frame 000111 with bitValid toggled 1,0,1,0... -> bits accepted only on bitValid=1; valid pulse with valueToPay=2; busy high throughout.
REQ-026 SHALL: after a legal 17, frame 001000 (8) -> error pulse; valueToPay stays 12.
REQ-027 SHALL: startIn reasserted after 3 bits, then full frame 011001 (25) -> one valid pulse, valueToPay=20, no error for the aborted frame.
REQ-028 SHALL: reset asserted mid-SHIFT after 4 bits -> all outputs 0 immediately, no pulse; next frame 000000 -> valid, valueToPay=0.
REQ-029 SHALL: with EXCESS5_DECODER_PARITY_EN, frame 001001+parity 0 -> valid, value 4; same frame + parity 1 -> error, valueToPay unchanged.
